mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_pkg.sv | 44 ++++
 rtl/mem_access_if.sv | 47 ++++
 rtl/mem_lane_format.sv | 56 +++++
 rtl/mem_access_unit.sv | 159 +++++++++++++++
 tb/tb_mem_access_unit.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_pkg
// Purpose  : Shared types for the memory access unit: FSM state encoding,
//            request size encoding and small request-decode helpers.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package mem_access_pkg;

    localparam int c_BUS_WIDTH = 32;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_ADDR = 3'd1,
        ST_RD_DATA = 3'd2,
        ST_WR      = 3'd3,
        ST_RESP    = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        SZ_BYTE     = 2'b00,
        SZ_HALF     = 2'b01,
        SZ_WORD     = 2'b10,
        SZ_WORD_ALT = 2'b11
    } size_t;

    // Fold the spare size code onto word so downstream logic sees 3 sizes.
    function automatic size_t norm_size(input logic [1:0] size);
        size_t s;
        s = size_t'(size);
        if (s == SZ_WORD_ALT) begin
            s = SZ_WORD;
        end
        return s;
    endfunction

    function automatic logic is_misaligned(input size_t size, input logic [1:0] offset);
        return ((size == SZ_HALF) && offset[0]) ||
               ((size == SZ_WORD) && (offset != 2'b00));
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_if
// Purpose  : Bundles the core-side request/response signals and the
//            memory-side bus of the memory access unit.
// Modports : slave  - the access unit (takes requests, drives memory bus)
//            master - the environment (core requester plus memory)
// Revision : 1.0 - initial release
// ============================================================================
interface mem_access_if #(
    parameter int BUS_WIDTH = 32
);
    // Core side
    logic                 req_valid;
    logic                 req_write;
    logic [1:0]           req_size;
    logic                 req_unsigned;
    logic [BUS_WIDTH-1:0] req_addr;
    logic [BUS_WIDTH-1:0] req_wdata;
    logic                 req_ready;
    logic                 resp_valid;
    logic [BUS_WIDTH-1:0] resp_rdata;
    logic                 resp_error;
    // Memory side
    logic                 mem_write_en;
    logic [BUS_WIDTH-1:0] mem_addr_write;
    logic [BUS_WIDTH-1:0] mem_data_write;
    logic [BUS_WIDTH-1:0] mem_addr_read;
    logic [BUS_WIDTH-1:0] mem_data_read;
    logic                 mem_ready;

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        input  mem_data_read, mem_ready,
        output req_ready, resp_valid, resp_rdata, resp_error,
        output mem_write_en, mem_addr_write, mem_data_write, mem_addr_read
    );

    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        output mem_data_read, mem_ready,
        input  req_ready, resp_valid, resp_rdata, resp_error,
        input  mem_write_en, mem_addr_write, mem_data_write, mem_addr_read
    );

endinterface
`default_nettype wire

// File: rtl/mem_lane_format.sv
`default_nettype none
// ============================================================================
// Module   : mem_lane_format
// Purpose  : Combinational little-endian lane handling.
//            Load path : extract byte/half at offset, sign- or zero-extend.
//            Store path: merge low bytes of wdata into the addressed lanes
//                        of the given word (word stores pass wdata through).
// Ports    : i_word       word read from memory (or captured copy)
//            i_offset     address bits [1:0]
//            i_size       normalised access size
//            i_unsigned   zero-extend loads when set
//            i_wdata      store data
//            o_load_data  extended load result
//            o_merge_data word to write back
// Revision : 1.0 - initial release
// ============================================================================
module mem_lane_format
    import mem_access_pkg::*;
#(
    parameter int BUS_WIDTH = 32
) (
    input  logic [BUS_WIDTH-1:0] i_word,
    input  logic [1:0]           i_offset,
    input  size_t                i_size,
    input  logic                 i_unsigned,
    input  logic [BUS_WIDTH-1:0] i_wdata,
    output logic [BUS_WIDTH-1:0] o_load_data,
    output logic [BUS_WIDTH-1:0] o_merge_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_word[{i_offset, 3'b000} +: 8];
    assign w_half = i_word[{i_offset[1], 4'b0000} +: 16];

    always_comb begin
        o_load_data = i_word;
        case (i_size)
            SZ_BYTE: o_load_data = {{(BUS_WIDTH-8){w_byte[7] & ~i_unsigned}}, w_byte};
            SZ_HALF: o_load_data = {{(BUS_WIDTH-16){w_half[15] & ~i_unsigned}}, w_half};
            default: o_load_data = i_word;
        endcase
    end

    always_comb begin
        o_merge_data = i_word;
        case (i_size)
            SZ_BYTE: o_merge_data[{i_offset, 3'b000} +: 8]     = i_wdata[7:0];
            SZ_HALF: o_merge_data[{i_offset[1], 4'b0000} +: 16] = i_wdata[15:0];
            default: o_merge_data = i_wdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit
// Purpose  : Single-outstanding load/store unit between a core and a word
//            memory with one-cycle registered read data. Byte/half stores
//            are done as read-modify-write; word stores write directly.
// Ports    : clk     - clock, posedge
//            nreset  - synchronous active-low reset
//            bus     - mem_access_if.slave (core request/response and
//                      memory read/write bus)
// Config   : MISALIGN_TRAP_EN - when defined, misaligned half/word requests
//            answer immediately with resp_error; otherwise the low address
//            bits are forced to alignment and resp_error is tied 0.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int BUS_WIDTH = 32
) (
    input  logic        clk,
    input  logic        nreset,
    mem_access_if.slave bus
);

    state_t               r_state;
    state_t               w_state_next;
    logic [BUS_WIDTH-1:0] r_addr;
    logic [BUS_WIDTH-1:0] r_wdata;
    logic [BUS_WIDTH-1:0] r_rdword;
    logic [BUS_WIDTH-1:0] r_resp_rdata;
    size_t                r_size;
    logic                 r_write;
    logic                 r_unsigned;
    logic                 r_resp_error;

    logic                 w_req_ready;
    logic                 w_accept;
    logic                 w_trap;
    logic                 w_resp_valid;
    size_t                w_req_size;
    logic [BUS_WIDTH-1:0] w_req_addr;
    logic [BUS_WIDTH-1:0] w_word_addr;
    logic [BUS_WIDTH-1:0] w_fmt_word;
    logic [BUS_WIDTH-1:0] w_load_data;
    logic [BUS_WIDTH-1:0] w_merge_data;

    // nreset is folded in so ready stays low for the whole reset cycle.
    assign w_req_ready = nreset && (r_state == ST_IDLE) && bus.mem_ready;
    assign w_accept    = bus.req_valid && w_req_ready;
    assign w_req_size  = norm_size(bus.req_size);

`ifdef MISALIGN_TRAP_EN
    assign w_trap     = is_misaligned(w_req_size, bus.req_addr[1:0]);
    assign w_req_addr = bus.req_addr;
`else
    assign w_trap = 1'b0;
    always_comb begin
        w_req_addr = bus.req_addr;
        if (w_req_size == SZ_HALF) begin
            w_req_addr[0] = 1'b0;
        end else if (w_req_size == SZ_WORD) begin
            w_req_addr[1:0] = 2'b00;
        end
    end
`endif

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_trap) begin
                        w_state_next = ST_RESP;
                    end else if (bus.req_write && (w_req_size == SZ_WORD)) begin
                        w_state_next = ST_WR;
                    end else begin
                        w_state_next = ST_RD_ADDR;
                    end
                end
            end
            ST_RD_ADDR: w_state_next = ST_RD_DATA;
            ST_RD_DATA: w_state_next = r_write ? ST_WR : ST_RESP;
            ST_WR:      w_state_next = ST_RESP;
            ST_RESP:    w_state_next = ST_IDLE;
            default:    w_state_next = ST_IDLE;
        endcase
    end

    // In WR the merge works on the word captured during RD_DATA; in RD_DATA
    // the load path works on the live memory read data.
    assign w_fmt_word = (r_state == ST_WR) ? r_rdword : bus.mem_data_read;

    mem_lane_format #(
        .BUS_WIDTH (BUS_WIDTH)
    ) u_lane_format (
        .i_word       (w_fmt_word),
        .i_offset     (r_addr[1:0]),
        .i_size       (r_size),
        .i_unsigned   (r_unsigned),
        .i_wdata      (r_wdata),
        .o_load_data  (w_load_data),
        .o_merge_data (w_merge_data)
    );

    assign w_word_addr  = {r_addr[BUS_WIDTH-1:2], 2'b00};
    assign w_resp_valid = (r_state == ST_RESP);

    assign bus.req_ready      = w_req_ready;
    assign bus.resp_valid     = w_resp_valid;
    assign bus.resp_rdata     = w_resp_valid ? r_resp_rdata : '0;
    assign bus.resp_error     = w_resp_valid & r_resp_error;
    assign bus.mem_write_en   = (r_state == ST_WR);
    assign bus.mem_addr_write = (r_state != ST_IDLE) ? w_word_addr : '0;
    assign bus.mem_addr_read  = (r_state != ST_IDLE) ? w_word_addr : '0;
    assign bus.mem_data_write = (r_state == ST_WR) ? w_merge_data : '0;

    always_ff @(posedge clk) begin
        if (!nreset) begin
            r_state      <= ST_IDLE;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_rdword     <= '0;
            r_resp_rdata <= '0;
            r_size       <= SZ_BYTE;
            r_write      <= 1'b0;
            r_unsigned   <= 1'b0;
            r_resp_error <= 1'b0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_addr       <= w_req_addr;
                        r_wdata      <= bus.req_wdata;
                        r_size       <= w_req_size;
                        r_write      <= bus.req_write;
                        r_unsigned   <= bus.req_unsigned;
                        r_resp_error <= w_trap;
                    end
                end
                ST_RD_DATA: begin
                    r_rdword <= bus.mem_data_read;
                    if (!r_write) begin
                        r_resp_rdata <= w_load_data;
                    end
                end
                ST_RESP: begin
                    r_resp_rdata <= '0;
                    r_resp_error <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_unit
// Purpose  : Directed self-checking bench for mem_access_unit with a small
//            word memory model (one-cycle registered read).
// Config   : MISALIGN_TRAP_EN selects the expected misaligned-half behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        nreset;
    int          n_tests = 0;
    int          n_fail  = 0;
    int          wr_count = 0;
    int          wr_base;
    logic [31:0] mem [0:255];
    logic        pl_en;
    logic [7:0]  pl_idx;
    logic [31:0] pl_data;

    mem_access_if #(.BUS_WIDTH(32)) bus ();

    mem_access_unit #(
        .BUS_WIDTH (32)
    ) dut (
        .clk    (clk),
        .nreset (nreset),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // Memory model: registered read, write on mem_write_en, bench preload port.
    always @(posedge clk) begin
        bus.mem_data_read <= mem[bus.mem_addr_read[9:2]];
        if (pl_en) begin
            mem[pl_idx] <= pl_data;
        end else if (bus.mem_write_en) begin
            mem[bus.mem_addr_write[9:2]] <= bus.mem_data_write;
        end
        if (bus.mem_write_en) begin
            wr_count <= wr_count + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [7:0] idx, input logic [31:0] data);
        pl_idx  = idx;
        pl_data = data;
        pl_en   = 1'b1;
        tick(1);
        pl_en   = 1'b0;
    endtask

    // Returns 1 time unit after the accept edge (first cycle after accept).
    task automatic issue(input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd, input logic keep);
        int budget;
        budget = 0;
        bus.req_write    = wr;
        bus.req_size     = sz;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wd;
        bus.req_valid    = 1'b1;
        while (!bus.req_ready && budget < 20) begin
            tick(1);
            budget++;
        end
        if (!bus.req_ready) check_eq("accept_timeout", {31'b0, bus.req_ready}, 32'd1);
        tick(1);
        if (!keep) bus.req_valid = 1'b0;
    endtask

    task automatic load_check(input string tag, input logic [1:0] sz, input logic uns,
                              input logic [31:0] addr, input logic [31:0] exp, input logic drop_rdy);
        issue(1'b0, sz, uns, addr, 32'h0, 1'b0);
        check_eq({tag, "_c1_valid"}, {31'b0, bus.resp_valid}, 32'd0);
        check_eq({tag, "_c1_raddr"}, bus.mem_addr_read, {addr[31:2], 2'b00});
        if (drop_rdy) bus.mem_ready = 1'b0;
        tick(1);
        check_eq({tag, "_c2_valid"}, {31'b0, bus.resp_valid}, 32'd0);
        tick(1);
        bus.mem_ready = 1'b1;
        check_eq({tag, "_c3_valid"}, {31'b0, bus.resp_valid}, 32'd1);
        check_eq({tag, "_c3_rdata"}, bus.resp_rdata, exp);
        check_eq({tag, "_c3_err"}, {31'b0, bus.resp_error}, 32'd0);
        tick(1);
        check_eq({tag, "_c4_valid"}, {31'b0, bus.resp_valid}, 32'd0);
        check_eq({tag, "_c4_rdata"}, bus.resp_rdata, 32'd0);
    endtask

    initial begin
        nreset           = 1'b0;
        pl_en            = 1'b0;
        pl_idx           = '0;
        pl_data          = '0;
        bus.req_valid    = 1'b0;
        bus.req_write    = 1'b0;
        bus.req_size     = 2'b00;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = '0;
        bus.req_wdata    = '0;
        bus.mem_ready    = 1'b1;
        tick(1);
        preload(8'd4, 32'h8899AABB);
        preload(8'd8, 32'h00000000);
        preload(8'd0, 32'h00000000);

        // Reset state
        check_eq("rst_ready", {31'b0, bus.req_ready}, 32'd0);
        check_eq("rst_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
        check_eq("rst_we", {31'b0, bus.mem_write_en}, 32'd0);
        check_eq("rst_raddr", bus.mem_addr_read, 32'd0);
        nreset = 1'b1;
        #1;
        check_eq("ready_after_rst", {31'b0, bus.req_ready}, 32'd1);

        // Acceptance gated by mem_ready; request while not ready is dropped
        bus.mem_ready    = 1'b0;
        bus.req_addr     = 32'h10;
        bus.req_size     = 2'b10;
        bus.req_valid    = 1'b1;
        #1;
        check_eq("ready_gated", {31'b0, bus.req_ready}, 32'd0);
        tick(2);
        check_eq("ignored_raddr", bus.mem_addr_read, 32'd0);
        bus.req_valid = 1'b0;
        bus.mem_ready = 1'b1;
        tick(1);

        // Loads of original word 0x8899AABB
        load_check("lb13", 2'b00, 1'b0, 32'h13, 32'hFFFFFF88, 1'b0);
        load_check("lbu13", 2'b00, 1'b1, 32'h13, 32'h00000088, 1'b1);

        // SB 0x5A at 0x11 (read-modify-write)
        wr_base = wr_count;
        issue(1'b1, 2'b00, 1'b0, 32'h11, 32'h0000005A, 1'b0);
        check_eq("sb_c1_we", {31'b0, bus.mem_write_en}, 32'd0);
        tick(1);
        check_eq("sb_c2_we", {31'b0, bus.mem_write_en}, 32'd0);
        tick(1);
        check_eq("sb_c3_we", {31'b0, bus.mem_write_en}, 32'd1);
        check_eq("sb_c3_wdata", bus.mem_data_write, 32'h88995ABB);
        check_eq("sb_c3_waddr", bus.mem_addr_write, 32'h10);
        tick(1);
        check_eq("sb_c4_valid", {31'b0, bus.resp_valid}, 32'd1);
        check_eq("sb_c4_rdata", bus.resp_rdata, 32'd0);
        check_eq("sb_c4_we", {31'b0, bus.mem_write_en}, 32'd0);
        tick(1);
        check_eq("sb_pulses", wr_count - wr_base, 32'd1);

        load_check("lw10", 2'b10, 1'b0, 32'h10, 32'h88995ABB, 1'b0);
        load_check("lb10", 2'b00, 1'b0, 32'h10, 32'hFFFFFFBB, 1'b0);
        load_check("lhu12", 2'b01, 1'b1, 32'h12, 32'h00008899, 1'b0);
        load_check("lh10", 2'b01, 1'b0, 32'h10, 32'h00005ABB, 1'b0);
        load_check("lw11sz", 2'b11, 1'b0, 32'h10, 32'h88995ABB, 1'b0);

        // SW 0x12345678 at 0x20: WR directly after accept
        wr_base = wr_count;
        issue(1'b1, 2'b10, 1'b0, 32'h20, 32'h12345678, 1'b0);
        check_eq("sw_c1_we", {31'b0, bus.mem_write_en}, 32'd1);
        check_eq("sw_c1_wdata", bus.mem_data_write, 32'h12345678);
        check_eq("sw_c1_waddr", bus.mem_addr_write, 32'h20);
        tick(1);
        check_eq("sw_c2_valid", {31'b0, bus.resp_valid}, 32'd1);
        check_eq("sw_c2_we", {31'b0, bus.mem_write_en}, 32'd0);
        tick(1);
        check_eq("sw_pulses", wr_count - wr_base, 32'd1);
        load_check("lw20", 2'b10, 1'b0, 32'h20, 32'h12345678, 1'b0);

        // Misaligned half at 0x13
`ifdef MISALIGN_TRAP_EN
        wr_base = wr_count;
        issue(1'b0, 2'b01, 1'b0, 32'h13, 32'h0, 1'b0);
        check_eq("lh13_c1_valid", {31'b0, bus.resp_valid}, 32'd1);
        check_eq("lh13_c1_err", {31'b0, bus.resp_error}, 32'd1);
        check_eq("lh13_c1_rdata", bus.resp_rdata, 32'd0);
        tick(1);
        check_eq("lh13_c2_err", {31'b0, bus.resp_error}, 32'd0);
        check_eq("lh13_no_write", wr_count - wr_base, 32'd0);
`else
        load_check("lh13", 2'b01, 1'b0, 32'h13, 32'hFFFF8899, 1'b0);
`endif

        // SH interrupted by reset while in RD_DATA
        preload(8'd4, 32'h8899AABB);
        wr_base = wr_count;
        issue(1'b1, 2'b01, 1'b0, 32'h10, 32'h00001234, 1'b0);
        tick(1);
        nreset = 1'b0;
        tick(1);
        check_eq("shrst_we", {31'b0, bus.mem_write_en}, 32'd0);
        check_eq("shrst_raddr_idle", bus.mem_addr_read, 32'd0);
        nreset = 1'b1;
        #1;
        check_eq("shrst_ready", {31'b0, bus.req_ready}, 32'd1);
        tick(3);
        check_eq("shrst_no_write", wr_count - wr_base, 32'd0);
        check_eq("shrst_word", mem[4], 32'h8899AABB);

        // Back-to-back LW with req_valid held high
        issue(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b1);
        check_eq("b2b_c1_ready", {31'b0, bus.req_ready}, 32'd0);
        tick(1);
        check_eq("b2b_c2_ready", {31'b0, bus.req_ready}, 32'd0);
        tick(1);
        check_eq("b2b_c3_ready", {31'b0, bus.req_ready}, 32'd0);
        check_eq("b2b_c3_rdata", bus.resp_rdata, 32'h12345678);
        bus.req_addr = 32'h10;
        tick(1);
        check_eq("b2b_c4_ready", {31'b0, bus.req_ready}, 32'd1);
        tick(1);
        bus.req_valid = 1'b0;
        check_eq("b2b_c5_ready", {31'b0, bus.req_ready}, 32'd0);
        check_eq("b2b_c5_raddr", bus.mem_addr_read, 32'h10);
        tick(2);
        check_eq("b2b_c7_valid", {31'b0, bus.resp_valid}, 32'd1);
        check_eq("b2b_c7_rdata", bus.resp_rdata, 32'h8899AABB);
        tick(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
